// File: rtl/umi_wr2mem.sv
// rtl/umi_wr2mem.sv - UMI write/posted-write endpoint driving a byte-masked word memory port
// One request in flight: IDLE accepts, MEM_WR issues the write, RESP returns the write response.
module umi_wr2mem #(
  parameter int CW    = 32,
  parameter int DW    = 128,
  parameter int AW    = 64,
  parameter int MAW   = 16,
  parameter int STRBW = DW/8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             udev_req_valid,
  input  logic [CW-1:0]    udev_req_cmd,
  input  logic [AW-1:0]    udev_req_dstaddr,
  input  logic [AW-1:0]    udev_req_srcaddr,
  input  logic [DW-1:0]    udev_req_data,
  output logic             udev_req_ready,
  output logic             udev_resp_valid,
  output logic [CW-1:0]    udev_resp_cmd,
  output logic [AW-1:0]    udev_resp_dstaddr,
  output logic [AW-1:0]    udev_resp_srcaddr,
  output logic [DW-1:0]    udev_resp_data,
  input  logic             udev_resp_ready,
  output logic             mem_valid,
  output logic [MAW-1:0]   mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic [STRBW-1:0] mem_wmask,
  input  logic             mem_ready,
  output logic             err_unsupported
);

  localparam int OW = $clog2(STRBW);
  localparam logic [4:0] REQ_WRITE  = 5'h03;
  localparam logic [4:0] REQ_POSTED = 5'h05;
  localparam logic [4:0] RESP_WRITE = 5'h04;
  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_DEVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, MEM_WR, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cmd_q;
  logic [AW-1:0]   dst_q, src_q;
  logic [DW-1:0]   data_q;
  logic [1:0]      err_q, err_d;
  logic            unsup_q, unsup_d;
  logic            fire;

  // Request-side decode used only for the accept decision
  logic [4:0]      req_opcode;
  logic [15:0]     req_nbytes;
  logic [16:0]     req_end;
  logic            req_legal;

  assign fire       = udev_req_valid && (state_q == IDLE);
  assign req_opcode = udev_req_cmd[4:0];
  assign req_nbytes = ({8'b0, udev_req_cmd[15:8]} + 16'd1) << udev_req_cmd[7:5];
  assign req_end    = {1'b0, req_nbytes} + 17'(udev_req_dstaddr[OW-1:0]);
  assign req_legal  = (req_end <= 17'(STRBW));

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unsup_d = unsup_q;
    case (state_q)
      IDLE: begin
        if (udev_req_valid) begin
          if (req_opcode == REQ_WRITE || req_opcode == REQ_POSTED) begin
            if (req_legal) begin
              state_d = MEM_WR;
              err_d   = ERR_OK;
            end else if (req_opcode == REQ_WRITE) begin
              state_d = RESP;
              err_d   = ERR_DEVERR;
            end
          end else begin
            unsup_d = 1'b1;
          end
        end
      end
      MEM_WR: begin
        if (mem_ready) begin
          state_d = (cmd_q[4:0] == REQ_WRITE) ? RESP : IDLE;
        end
      end
      RESP: begin
        if (udev_resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      err_q   <= ERR_OK;
      unsup_q <= 1'b0;
      cmd_q   <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      unsup_q <= unsup_d;
      if (fire) begin
        cmd_q  <= udev_req_cmd;
        dst_q  <= udev_req_dstaddr;
        src_q  <= udev_req_srcaddr;
        data_q <= udev_req_data;
      end
    end
  end

  // Memory port is driven purely from the latched request
  logic [OW-1:0] off_q;
  logic [15:0]   nbytes_q;
  logic [16:0]   end_q;

  assign off_q    = dst_q[OW-1:0];
  assign nbytes_q = ({8'b0, cmd_q[15:8]} + 16'd1) << cmd_q[7:5];
  assign end_q    = {1'b0, nbytes_q} + 17'(off_q);

  always_comb begin
    mem_wmask = '0;
    for (int i = 0; i < STRBW; i++) begin
      mem_wmask[i] = (17'(i) >= 17'(off_q)) && (17'(i) < end_q);
    end
  end

  assign mem_wdata = data_q << {off_q, 3'b000};
  assign mem_addr  = dst_q[MAW+OW-1:OW];
  assign mem_valid = (state_q == MEM_WR);

  assign udev_req_ready    = (state_q == IDLE);
  assign udev_resp_valid   = (state_q == RESP);
  // hostid, err, ex=0, eof=0, eom, prot, qos, len, size, opcode
  assign udev_resp_cmd     = CW'({cmd_q[31:27], err_q, 1'b0, 1'b0, cmd_q[22],
                                  cmd_q[21:20], cmd_q[19:16], cmd_q[15:8],
                                  cmd_q[7:5], RESP_WRITE});
  assign udev_resp_dstaddr = src_q;
  assign udev_resp_srcaddr = dst_q;
  assign udev_resp_data    = '0;
  assign err_unsupported   = unsup_q;

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^cmd_q[26:23];

endmodule

// File: tb/tb_umi_wr2mem.sv
// tb/tb_umi_wr2mem.sv - directed self-checking bench for umi_wr2mem
module tb_umi_wr2mem;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          udev_req_valid = 1'b0;
  logic [31:0]   udev_req_cmd = '0;
  logic [63:0]   udev_req_dstaddr = '0;
  logic [63:0]   udev_req_srcaddr = '0;
  logic [127:0]  udev_req_data = '0;
  logic          udev_req_ready;
  logic          udev_resp_valid;
  logic [31:0]   udev_resp_cmd;
  logic [63:0]   udev_resp_dstaddr;
  logic [63:0]   udev_resp_srcaddr;
  logic [127:0]  udev_resp_data;
  logic          udev_resp_ready = 1'b1;
  logic          mem_valid;
  logic [15:0]   mem_addr;
  logic [127:0]  mem_wdata;
  logic [15:0]   mem_wmask;
  logic          mem_ready = 1'b1;
  logic          err_unsupported;

  int checks = 0;
  int errors = 0;
  int mem_cnt = 0;
  int resp_cnt = 0;
  int mem_base, resp_base;
  logic [127:0] full_data;

  umi_wr2mem dut (
    .clk(clk), .nreset(nreset),
    .udev_req_valid(udev_req_valid), .udev_req_cmd(udev_req_cmd),
    .udev_req_dstaddr(udev_req_dstaddr), .udev_req_srcaddr(udev_req_srcaddr),
    .udev_req_data(udev_req_data), .udev_req_ready(udev_req_ready),
    .udev_resp_valid(udev_resp_valid), .udev_resp_cmd(udev_resp_cmd),
    .udev_resp_dstaddr(udev_resp_dstaddr), .udev_resp_srcaddr(udev_resp_srcaddr),
    .udev_resp_data(udev_resp_data), .udev_resp_ready(udev_resp_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .err_unsupported(err_unsupported)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_valid && mem_ready) mem_cnt++;
    if (udev_resp_valid && udev_resp_ready) resp_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request; the DUT is expected to be in IDLE so it fires on this edge
  task automatic send(input logic [4:0] op, input logic [2:0] size, input logic [7:0] len,
                      input logic [31:0] extra, input logic [63:0] dst, input logic [63:0] src,
                      input logic [127:0] data);
    udev_req_valid   = 1'b1;
    udev_req_cmd     = extra | {16'b0, len, size, op};
    udev_req_dstaddr = dst;
    udev_req_srcaddr = src;
    udev_req_data    = data;
    step();
    udev_req_valid   = 1'b0;
  endtask

  initial begin
    full_data = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

    // Reset state
    #12;
    chk("rst_req_ready", 128'(udev_req_ready), 128'd1);
    chk("rst_resp_valid", 128'(udev_resp_valid), 128'd0);
    chk("rst_mem_valid", 128'(mem_valid), 128'd0);
    chk("rst_err_unsup", 128'(err_unsupported), 128'd0);
    nreset = 1'b1;
    step();

    // Aligned full word; hostid=3, eom, prot=1, qos=2 carried into the response
    send(5'h03, 3'd0, 8'd15, 32'h18520000, 64'h1000, 64'hABC0, full_data);
    chk("full_mem_valid", 128'(mem_valid), 128'd1);
    chk("full_req_ready", 128'(udev_req_ready), 128'd0);
    chk("full_mem_addr", 128'(mem_addr), 128'h100);
    chk("full_mem_wmask", 128'(mem_wmask), 128'hFFFF);
    chk("full_mem_wdata", mem_wdata, full_data);
    step();
    chk("full_resp_valid", 128'(udev_resp_valid), 128'd1);
    chk("full_mem_valid_off", 128'(mem_valid), 128'd0);
    chk("full_resp_cmd", 128'(udev_resp_cmd), 128'h18520F04);
    chk("full_resp_dst", 128'(udev_resp_dstaddr), 128'hABC0);
    chk("full_resp_src", 128'(udev_resp_srcaddr), 128'h1000);
    chk("full_resp_data", udev_resp_data, 128'd0);
    step();
    chk("full_ready_again", 128'(udev_req_ready), 128'd1);
    chk("full_counts", 128'({mem_cnt, resp_cnt}), {64'd0, 32'd1, 32'd1});

    // Partial unaligned
    send(5'h03, 3'd0, 8'd3, 32'h0, 64'h1005, 64'h20, 128'hDDCCBBAA);
    chk("part_mem_addr", 128'(mem_addr), 128'h100);
    chk("part_mem_wmask", 128'(mem_wmask), 128'h01E0);
    chk("part_mem_wdata", mem_wdata, 128'h00000000_000000DD_CCBBAA00_00000000);
    step();
    chk("part_resp_cmd", 128'(udev_resp_cmd), 128'h00000304);
    step();

    // size=1 ending exactly on the word boundary
    send(5'h03, 3'd1, 8'd3, 32'h0, 64'h1008, 64'h20, 128'h1122334455667788);
    chk("edge_mem_valid", 128'(mem_valid), 128'd1);
    chk("edge_mem_wmask", 128'(mem_wmask), 128'hFF00);
    chk("edge_mem_wdata", mem_wdata, 128'h11223344_55667788_00000000_00000000);
    step();
    chk("edge_resp_cmd", 128'(udev_resp_cmd), 128'h00000324);
    step();

    // Boundary cross, non-posted: error response, no memory access
    mem_base = mem_cnt;
    send(5'h03, 3'd0, 8'd3, 32'h0, 64'h100E, 64'h40, 128'h1);
    chk("bx_mem_valid", 128'(mem_valid), 128'd0);
    chk("bx_resp_valid", 128'(udev_resp_valid), 128'd1);
    chk("bx_resp_cmd", 128'(udev_resp_cmd), 128'h04000304);
    chk("bx_resp_dst", 128'(udev_resp_dstaddr), 128'h40);
    step();
    chk("bx_ready_again", 128'(udev_req_ready), 128'd1);

    // Boundary cross, posted: silently dropped
    resp_base = resp_cnt;
    send(5'h05, 3'd0, 8'd3, 32'h0, 64'h100E, 64'h40, 128'h1);
    chk("bxp_req_ready", 128'(udev_req_ready), 128'd1);
    chk("bxp_mem_valid", 128'(mem_valid), 128'd0);
    chk("bxp_resp_valid", 128'(udev_resp_valid), 128'd0);
    step();
    chk("bx_no_mem", 128'(mem_cnt - mem_base), 128'd0);
    chk("bxp_no_resp", 128'(resp_cnt - resp_base), 128'd0);

    // Legal posted write: memory write, no response, ready after 2 cycles
    resp_base = resp_cnt;
    send(5'h05, 3'd0, 8'd1, 32'h0, 64'h3002, 64'h0, 128'hBEEF);
    chk("post_mem_valid", 128'(mem_valid), 128'd1);
    chk("post_mem_addr", 128'(mem_addr), 128'h300);
    chk("post_mem_wmask", 128'(mem_wmask), 128'h000C);
    step();
    chk("post_ready", 128'(udev_req_ready), 128'd1);
    chk("post_resp_valid", 128'(udev_resp_valid), 128'd0);
    chk("post_no_resp", 128'(resp_cnt - resp_base), 128'd0);

    // Backpressure on both sides
    mem_base = mem_cnt;
    resp_base = resp_cnt;
    mem_ready = 1'b0;
    udev_resp_ready = 1'b0;
    send(5'h03, 3'd0, 8'd7, 32'h0, 64'h2010, 64'h55, 128'h8877665544332211);
    for (int i = 0; i < 5; i++) begin
      chk("bp_mem_valid", 128'(mem_valid), 128'd1);
      chk("bp_mem_addr", 128'(mem_addr), 128'h201);
      chk("bp_mem_wmask", 128'(mem_wmask), 128'h00FF);
      chk("bp_mem_wdata", mem_wdata, 128'h8877665544332211);
      chk("bp_req_ready", 128'(udev_req_ready), 128'd0);
      step();
    end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_resp_valid", 128'(udev_resp_valid), 128'd1);
      chk("bp_resp_cmd", 128'(udev_resp_cmd), 128'h00000704);
      chk("bp_resp_dst", 128'(udev_resp_dstaddr), 128'h55);
      chk("bp_resp_src", 128'(udev_resp_srcaddr), 128'h2010);
      chk("bp_req_ready2", 128'(udev_req_ready), 128'd0);
      step();
    end
    udev_resp_ready = 1'b1;
    step();
    mem_ready = 1'b1;
    chk("bp_ready_again", 128'(udev_req_ready), 128'd1);
    chk("bp_one_mem", 128'(mem_cnt - mem_base), 128'd1);
    chk("bp_one_resp", 128'(resp_cnt - resp_base), 128'd1);

    // Unsupported opcode, then a normal write
    send(5'h01, 3'd0, 8'd3, 32'h0, 64'h1000, 64'h0, 128'h0);
    chk("unsup_flag", 128'(err_unsupported), 128'd1);
    chk("unsup_ready", 128'(udev_req_ready), 128'd1);
    chk("unsup_mem_valid", 128'(mem_valid), 128'd0);
    send(5'h03, 3'd0, 8'd0, 32'h0, 64'h1001, 64'h8, 128'h5A);
    chk("unsup_next_mem", 128'(mem_valid), 128'd1);
    chk("unsup_next_mask", 128'(mem_wmask), 128'h0002);
    step();
    chk("unsup_next_resp", 128'(udev_resp_valid), 128'd1);
    step();
    chk("unsup_sticky", 128'(err_unsupported), 128'd1);

    // Asynchronous reset while in MEM_WR
    mem_base = mem_cnt;
    resp_base = resp_cnt;
    mem_ready = 1'b0;
    send(5'h03, 3'd0, 8'd3, 32'h0, 64'h1000, 64'h8, 128'h1);
    chk("mid_mem_valid", 128'(mem_valid), 128'd1);
    #2 nreset = 1'b0;
    #1;
    chk("mid_rst_mem_valid", 128'(mem_valid), 128'd0);
    chk("mid_rst_ready", 128'(udev_req_ready), 128'd1);
    chk("mid_rst_unsup", 128'(err_unsupported), 128'd0);
    mem_ready = 1'b1;
    step();
    nreset = 1'b1;
    step();
    step();
    step();
    chk("mid_no_resp_valid", 128'(udev_resp_valid), 128'd0);
    chk("mid_no_mem", 128'(mem_cnt - mem_base), 128'd0);
    chk("mid_no_resp", 128'(resp_cnt - resp_base), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
